sdram_pixel_unpacker: RTL and testbench

Display-side read engine for the SDRAM frame buffer. It pulls paired 16-bit words from the two SDRAM read FIFOs, unpacks them back into 8-bit R/G/B, and presents one pixel per LCD data request. It undoes the write-side packing exactly: word 1 = {0, G[11:7], B[11:2]}, word 2 = {0, G[6:2], R[11:2]}. It sits between the SDRAM controller read ports and the LCD timing controller, and tracks frame position and FIFO underruns.

---
 rtl/sdram_pixel_unpacker.sv | 160 ++++++++++++++++
 tb/tb_sdram_pixel_unpacker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pixel_unpacker.sv
// Display-side SDRAM frame buffer reader: pops paired 16-bit words from the two
// read FIFOs, rebuilds 8-bit R/G/B and presents one pixel per LCD request.
module sdram_pixel_unpacker #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iFrame_start,
    input  logic        iRequest,
    input  logic        iRd1_empty,
    input  logic        iRd2_empty,
    input  logic [15:0] iRd1_data,
    input  logic [15:0] iRd2_data,
    output logic        oRd1_req,
    output logic        oRd2_req,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oValid,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oUnderrun,
    output logic [15:0] oUnderrun_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stateType;

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

    stateType    stateReg;
    stateType    stateNext;
    logic        accept;
    logic        fifosReady;
    logic        underrun;
    logic        lastPixel;
    logic [15:0] xReg;
    logic [15:0] yReg;
    logic        s1ValidReg;
    logic        s1BlackReg;
    logic [15:0] s1XReg;
    logic [15:0] s1YReg;

    // Padding and low-order bits of both words carry no pixel information.
    logic unusedBits;
    assign unusedBits = ^{iRd1_data[15], iRd1_data[1:0],
                          iRd2_data[15], iRd2_data[11:10], iRd2_data[1:0]};

    assign lastPixel = (xReg == X_LAST) && (yReg == Y_LAST);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        if (iFrame_start) begin
            stateNext = STREAM;
        end else begin
            case (stateReg)
                STREAM:  if (accept && lastPixel) stateNext = DONE;
                default: stateNext = stateReg;
            endcase
        end
    end

    // Both strobes come from one term so the FIFOs never drift out of word alignment.
    always_comb begin
        accept     = iRequest && (stateReg == STREAM) && !iFrame_start;
        fifosReady = !iRd1_empty && !iRd2_empty;
        oRd1_req   = accept && fifosReady;
        oRd2_req   = accept && fifosReady;
        underrun   = accept && !fifosReady;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            xReg <= '0;
            yReg <= '0;
        end else if (iFrame_start) begin
            xReg <= '0;
            yReg <= '0;
        end else if (accept) begin
            if (xReg == X_LAST) begin
                xReg <= '0;
                yReg <= yReg + 16'd1;
            end else begin
                xReg <= xReg + 16'd1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oUnderrun     <= 1'b0;
            oUnderrun_cnt <= '0;
        end else if (iFrame_start) begin
            oUnderrun     <= 1'b0;
            oUnderrun_cnt <= '0;
        end else if (underrun) begin
            oUnderrun <= 1'b1;
            if (oUnderrun_cnt != 16'hFFFF) begin
                oUnderrun_cnt <= oUnderrun_cnt + 16'd1;
            end
        end
    end

    // Stage 1 waits for the FIFO data that arrives one cycle after the strobe.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1ValidReg <= 1'b0;
            s1BlackReg <= 1'b0;
            s1XReg     <= '0;
            s1YReg     <= '0;
        end else begin
            s1ValidReg <= accept;
            s1BlackReg <= underrun;
            if (accept) begin
                s1XReg <= xReg;
                s1YReg <= yReg;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid <= 1'b0;
            oR     <= '0;
            oG     <= '0;
            oB     <= '0;
            oX     <= '0;
            oY     <= '0;
        end else begin
            oValid <= s1ValidReg;
            if (s1ValidReg) begin
                oX <= s1XReg;
                oY <= s1YReg;
                if (s1BlackReg) begin
                    oR <= '0;
                    oG <= '0;
                    oB <= '0;
                end else begin
                    oR <= iRd2_data[9:2];
                    oG <= {iRd1_data[14:10], iRd2_data[14:12]};
                    oB <= iRd1_data[9:2];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_pixel_unpacker.sv
// Bench for sdram_pixel_unpacker: a small 4x2 frame and a tall 4x20000 frame share
// the control stimulus; a pixel-level model checks both every cycle.
module tb_sdram_pixel_unpacker;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    logic frameStart = 1'b0;
    logic request = 1'b0;
    logic rd1Empty = 1'b0;
    logic rd2Empty = 1'b0;

    logic [15:0] rd1Data [2];
    logic [15:0] rd2Data [2];
    logic        rdReq1 [2];
    logic        rdReq2 [2];
    logic [7:0]  oR [2];
    logic [7:0]  oG [2];
    logic [7:0]  oB [2];
    logic        oValid [2];
    logic [15:0] oX [2];
    logic [15:0] oY [2];
    logic        oUnd [2];
    logic [15:0] oCnt [2];

    int checks = 0;
    int failures = 0;
    int printed = 0;

    always #5 iClk = ~iClk;

    sdram_pixel_unpacker #(.H_ACTIVE(4), .V_ACTIVE(2)) uSmall (
        .iClk(iClk), .iRst(iRst), .iFrame_start(frameStart), .iRequest(request),
        .iRd1_empty(rd1Empty), .iRd2_empty(rd2Empty),
        .iRd1_data(rd1Data[0]), .iRd2_data(rd2Data[0]),
        .oRd1_req(rdReq1[0]), .oRd2_req(rdReq2[0]),
        .oR(oR[0]), .oG(oG[0]), .oB(oB[0]), .oValid(oValid[0]),
        .oX(oX[0]), .oY(oY[0]), .oUnderrun(oUnd[0]), .oUnderrun_cnt(oCnt[0])
    );

    sdram_pixel_unpacker #(.H_ACTIVE(4), .V_ACTIVE(20000)) uBig (
        .iClk(iClk), .iRst(iRst), .iFrame_start(frameStart), .iRequest(request),
        .iRd1_empty(rd1Empty), .iRd2_empty(rd2Empty),
        .iRd1_data(rd1Data[1]), .iRd2_data(rd2Data[1]),
        .oRd1_req(rdReq1[1]), .oRd2_req(rdReq2[1]),
        .oR(oR[1]), .oG(oG[1]), .oB(oB[1]), .oValid(oValid[1]),
        .oX(oX[1]), .oY(oY[1]), .oUnderrun(oUnd[1]), .oUnderrun_cnt(oCnt[1])
    );

    // Frame buffer contents as 12-bit pixels; FIFO words are packed from them.
    logic [11:0] pixR [256];
    logic [11:0] pixG [256];
    logic [11:0] pixB [256];
    bit          junk1 [256];
    bit          junk2 [256];

    function automatic logic [15:0] word1(int i);
        return {junk1[i], pixG[i][11:7], pixB[i][11:2]};
    endfunction

    function automatic logic [15:0] word2(int i);
        return {junk2[i], pixG[i][6:2], pixR[i][11:2]};
    endfunction

    function automatic int vOf(int k);
        return (k == 0) ? 2 : 20000;
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", nm, k, act, exp, $time);
            end
        end
    endtask

    // FIFO emulation: a strobe returns the next word pair one cycle later.
    int emuIdx [2] = '{0, 0};
    always @(posedge iClk) begin
        for (int k = 0; k < 2; k++) begin
            if (rdReq1[k]) begin
                rd1Data[k] <= word1(emuIdx[k] & 255);
                rd2Data[k] <= word2(emuIdx[k] & 255);
                emuIdx[k]  <= emuIdx[k] + 1;
            end
        end
    end

    // Model: frame position, underrun bookkeeping and a two-deep pixel delay line.
    bit       mActive [2];
    int       mX [2];
    int       mY [2];
    bit       mUnd [2];
    int       mCnt [2];
    int       mRdIdx [2];
    bit       p1Valid [2];
    bit [23:0] p1Rgb [2];
    int       p1X [2];
    int       p1Y [2];
    bit       eValid [2];
    bit [23:0] eRgb [2];
    int       eX [2];
    int       eY [2];

    always @(posedge iClk or posedge iRst) begin
        for (int k = 0; k < 2; k++) begin
            if (iRst) begin
                mActive[k] <= 1'b0; mX[k] <= 0; mY[k] <= 0; mUnd[k] <= 1'b0; mCnt[k] <= 0;
                p1Valid[k] <= 1'b0; p1Rgb[k] <= '0; p1X[k] <= 0; p1Y[k] <= 0;
                eValid[k] <= 1'b0; eRgb[k] <= '0; eX[k] <= 0; eY[k] <= 0;
            end else begin
                automatic bit acc = mActive[k] && request && !frameStart;
                automatic bit rd = acc && !rd1Empty && !rd2Empty;
                automatic int idx = mRdIdx[k] & 255;
                eValid[k] <= p1Valid[k];
                if (p1Valid[k]) begin
                    eRgb[k] <= p1Rgb[k];
                    eX[k]   <= p1X[k];
                    eY[k]   <= p1Y[k];
                end
                p1Valid[k] <= acc;
                if (acc) begin
                    p1X[k]   <= mX[k];
                    p1Y[k]   <= mY[k];
                    p1Rgb[k] <= rd ? {pixR[idx][11:4], pixG[idx][11:4], pixB[idx][11:4]} : 24'h0;
                end
                if (rd) mRdIdx[k] <= mRdIdx[k] + 1;
                if (frameStart) begin
                    mActive[k] <= 1'b1; mX[k] <= 0; mY[k] <= 0; mUnd[k] <= 1'b0; mCnt[k] <= 0;
                end else if (acc) begin
                    if (mX[k] == 3 && mY[k] == vOf(k) - 1) mActive[k] <= 1'b0;
                    if (mX[k] == 3) begin
                        mX[k] <= 0;
                        mY[k] <= mY[k] + 1;
                    end else begin
                        mX[k] <= mX[k] + 1;
                    end
                    if (!rd) begin
                        mUnd[k] <= 1'b1;
                        if (mCnt[k] < 65535) mCnt[k] <= mCnt[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge iClk) begin
        for (int k = 0; k < 2; k++) begin
            automatic bit expReq = mActive[k] && request && !frameStart && !rd1Empty && !rd2Empty;
            chk("rd1_req", k, 64'(rdReq1[k]), 64'(expReq));
            chk("rd2_req", k, 64'(rdReq2[k]), 64'(expReq));
            chk("valid", k, 64'(oValid[k]), 64'(eValid[k]));
            chk("rgb", k, 64'({oR[k], oG[k], oB[k]}), 64'(eRgb[k]));
            chk("xy", k, 64'({oX[k], oY[k]}), 64'({eX[k][15:0], eY[k][15:0]}));
            chk("underrun", k, 64'(oUnd[k]), 64'(mUnd[k]));
            chk("underrun_cnt", k, 64'(oCnt[k]), 64'(mCnt[k]));
        end
    end

    // Record of the small instance's strobes and presented pixels.
    int          strobeCnt = 0;
    logic [55:0] pixQ [$];
    always @(negedge iClk) begin
        if (rdReq1[0]) strobeCnt <= strobeCnt + 1;
        if (oValid[0]) pixQ.push_back({oR[0], oG[0], oB[0], oX[0], oY[0]});
    end

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic pulseFrame();
        frameStart = 1'b1;
        step(1);
        frameStart = 1'b0;
    endtask

    int expXs [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int expYs [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        int sBase;
        int qBase;
        // Pixel 0 packs to d1=0x7FFC, d2=0x2A58.
        pixR[0] = 12'h960; pixG[0] = 12'hFA8; pixB[0] = 12'hFF0; junk1[0] = 0; junk2[0] = 0;
        for (int i = 1; i < 256; i++) begin
            pixR[i] = 12'($urandom); pixG[i] = 12'($urandom); pixB[i] = 12'($urandom);
            junk1[i] = 1'($urandom); junk2[i] = 1'($urandom);
        end
        rd1Data[0] = '0; rd1Data[1] = '0; rd2Data[0] = '0; rd2Data[1] = '0;

        step(3);
        chk("lit_rst_valid", 0, 64'(oValid[0]), 64'd0);
        chk("lit_rst_rgbxy", 0, 64'({oR[0], oG[0], oB[0], oX[0], oY[0]}), 64'd0);
        chk("lit_rst_und", 0, 64'({oUnd[0], oCnt[0]}), 64'd0);
        iRst = 1'b0;

        // Requests in IDLE are ignored.
        sBase = strobeCnt;
        request = 1'b1;
        step(3);
        request = 1'b0;
        step(2);
        chk("lit_idle_strobes", 0, 64'(strobeCnt - sBase), 64'd0);

        // Full 4x2 frame.
        pulseFrame();
        sBase = strobeCnt;
        qBase = pixQ.size();
        request = 1'b1;
        step(8);
        request = 1'b0;
        step(3);
        chk("lit_frame_strobes", 0, 64'(strobeCnt - sBase), 64'd8);
        chk("lit_frame_pixels", 0, 64'(pixQ.size() - qBase), 64'd8);
        if (pixQ.size() > qBase) begin
            chk("lit_unpack_rgb", 0, 64'(pixQ[qBase][55:32]), 64'h96FAFF);
        end
        for (int i = 0; i < 8 && qBase + i < pixQ.size(); i++) begin
            chk("lit_frame_xy", i, 64'(pixQ[qBase + i][31:0]), 64'({expXs[i][15:0], expYs[i][15:0]}));
        end

        // A 9th request after the frame is complete.
        sBase = strobeCnt;
        qBase = pixQ.size();
        request = 1'b1;
        step(1);
        request = 1'b0;
        step(3);
        chk("lit_done_strobes", 0, 64'(strobeCnt - sBase), 64'd0);
        chk("lit_done_pixels", 0, 64'(pixQ.size() - qBase), 64'd0);

        // Frame start colliding with a request mid-frame.
        pulseFrame();
        request = 1'b1;
        step(3);
        frameStart = 1'b1;
        #1;
        chk("lit_collide_strobe", 0, 64'(rdReq1[0]), 64'd0);
        step(1);
        frameStart = 1'b0;
        step(1);
        request = 1'b0;
        step(1);
        chk("lit_collide_valid", 0, 64'(oValid[0]), 64'd1);
        chk("lit_collide_xy", 0, 64'({oX[0], oY[0]}), 64'd0);

        // Underrun on FIFO 2 only.
        pulseFrame();
        rd2Empty = 1'b1;
        request = 1'b1;
        #1;
        chk("lit_und_strobes", 0, 64'({rdReq1[0], rdReq2[0]}), 64'd0);
        step(1);
        request = 1'b0;
        rd2Empty = 1'b0;
        step(1);
        chk("lit_und_valid", 0, 64'(oValid[0]), 64'd1);
        chk("lit_und_black", 0, 64'({oR[0], oG[0], oB[0]}), 64'd0);
        chk("lit_und_flag", 0, 64'({oUnd[0], oCnt[0]}), 64'h10001);
        request = 1'b1;
        step(1);
        request = 1'b0;
        step(1);
        chk("lit_und_x", 0, 64'({oValid[0], oX[0]}), 64'h10001);
        pulseFrame();
        chk("lit_und_clear", 0, 64'({oUnd[0], oCnt[0]}), 64'd0);

        // Asynchronous reset during a stream.
        pulseFrame();
        request = 1'b1;
        step(3);
        #2;
        iRst = 1'b1;
        #1;
        chk("lit_rst_strobes", 0, 64'({rdReq1[0], rdReq2[0], rdReq1[1], rdReq2[1]}), 64'd0);
        chk("lit_rst_outs", 0, 64'({oValid[0], oR[0], oG[0], oB[0], oX[0], oY[0]}), 64'd0);
        step(2);
        iRst = 1'b0;
        step(3);
        chk("lit_rst_idle", 0, 64'({rdReq1[0], oValid[0]}), 64'd0);
        request = 1'b0;
        step(2);

        // Saturating underrun counter.
        pulseFrame();
        rd1Empty = 1'b1;
        request = 1'b1;
        step(65540);
        request = 1'b0;
        rd1Empty = 1'b0;
        step(3);
        chk("lit_sat_cnt", 1, 64'({oUnd[1], oCnt[1]}), 64'h1FFFF);
        chk("lit_small_cnt", 0, 64'({oUnd[0], oCnt[0]}), 64'h10008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
